// File: rtl/math_pipelined_arbiter_pkg.sv
// Shared definitions for the pipelined add/sub arbiter: op codes, FSM encoding
// and a constant-foldable ceil(log2) helper.
package math_pipelined_arbiter_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/math_pipelined_arbiter_rr_arbiter.sv
// Combinational round-robin grant: one-hot on the first valid request at or
// after rr_ptr (wrapping), plus the pointer value that follows the winner.
module rr_arbiter
  import math_pipelined_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]  rr_ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_id,
  output logic             grant_any,
  output logic [ID_W-1:0]  next_ptr
);

  int   cand_s;
  logic hit_s;

  // Upward search from rr_ptr; the first hit blocks all later candidates.
  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    cand_s    = 0;
    hit_s     = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_s        = (int'(rr_ptr) + k) % N_REQ;
      hit_s         = !grant_any && req_valid[cand_s];
      grant[cand_s] = grant[cand_s] | hit_s;
      grant_id      = hit_s ? ID_W'(cand_s) : grant_id;
      grant_any     = grant_any | hit_s;
    end
  end

  // Pointer advances to the requester just after the winner, with wrap.
  always_comb begin
    if (grant_id == ID_W'(N_REQ - 1)) begin
      next_ptr = '0;
    end else begin
      next_ptr = grant_id + 1'b1;
    end
  end

endmodule

// File: rtl/math_pipelined_arbiter.sv
// Round-robin front end sharing one pipelined add/sub unit between N_REQ
// requesters; one operation in flight, result returned over valid/ready.
module math_pipelined_arbiter
  import math_pipelined_arbiter_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int ALU_LATENCY = 4,
  parameter int N_REQ       = 4,
  localparam int ID_W       = clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ-1:0]   req_op,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]   req_ready,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [ID_W-1:0]    rsp_id,
  output logic [WIDTH-1:0]   rsp_data,
  output logic               alu_ce,
  output logic [WIDTH-1:0]   alu_i1,
  output logic [WIDTH-1:0]   alu_i2,
  input  logic [WIDTH-1:0]   alu_sum,
  input  logic [WIDTH-1:0]   alu_sub
);

  localparam int CNT_W = clog2(ALU_LATENCY + 1);

  state_t             state_r;
  state_t             state_s;
  logic [ID_W-1:0]    rr_ptr_r;
  logic               op_r;
  logic [ID_W-1:0]    id_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               alu_ce_r;
  logic [WIDTH-1:0]   alu_i1_r;
  logic [WIDTH-1:0]   alu_i2_r;
  logic               rsp_valid_r;
  logic [ID_W-1:0]    rsp_id_r;
  logic [WIDTH-1:0]   rsp_data_r;

  logic [N_REQ-1:0]   grant_s;
  logic [ID_W-1:0]    grant_id_s;
  logic               grant_any_s;
  logic [ID_W-1:0]    next_ptr_s;
  logic               take_s;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_r),
    .grant     (grant_s),
    .grant_id  (grant_id_s),
    .grant_any (grant_any_s),
    .next_ptr  (next_ptr_s)
  );

  // Grants are offered only while idle and out of reset.
  always_comb begin
    if ((state_r == ST_IDLE) && rst_n) begin
      req_ready = grant_s;
    end else begin
      req_ready = '0;
    end
  end

  assign take_s = (state_r == ST_IDLE) && grant_any_s;

  // Next-state logic for the grant/load/run/respond sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_any_s) begin
          state_s = ST_LOAD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: state_s = ST_RUN;
      ST_RUN: begin
        if (cnt_r == '0) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (rsp_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand capture, latency counter and response registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_r    <= '0;
      op_r        <= OP_ADD;
      id_r        <= '0;
      cnt_r       <= '0;
      alu_ce_r    <= 1'b0;
      alu_i1_r    <= '0;
      alu_i2_r    <= '0;
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= '0;
      rsp_data_r  <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (take_s) begin
            alu_i1_r <= req_a[int'(grant_id_s)*WIDTH +: WIDTH];
            alu_i2_r <= req_b[int'(grant_id_s)*WIDTH +: WIDTH];
            op_r     <= req_op[grant_id_s];
            id_r     <= grant_id_s;
            rr_ptr_r <= next_ptr_s;
            alu_ce_r <= 1'b1;
          end
        end
        ST_LOAD: begin
          alu_ce_r <= 1'b0;
          cnt_r    <= CNT_W'(ALU_LATENCY - 1);
        end
        ST_RUN: begin
          // cnt_r reaching zero lands exactly ALU_LATENCY edges after the ce cycle.
          if (cnt_r == '0) begin
            rsp_data_r  <= (op_r == OP_SUB) ? alu_sub : alu_sum;
            rsp_id_r    <= id_r;
            rsp_valid_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r - 1'b1;
          end
        end
        ST_DONE: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
          end
        end
        default: begin
          alu_ce_r    <= 1'b0;
          rsp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign alu_ce    = alu_ce_r;
  assign alu_i1    = alu_i1_r;
  assign alu_i2    = alu_i2_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_id    = rsp_id_r;
  assign rsp_data  = rsp_data_r;

endmodule

// File: tb/tb_math_pipelined_arbiter.sv
// Directed + randomized bench for math_pipelined_arbiter with a behavioural
// model of the shared add/sub unit and a round-robin reference model.
module tb_math_pipelined_arbiter;

  localparam int WIDTH       = 16;
  localparam int ALU_LATENCY = 4;
  localparam int N_REQ       = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = 4'd0;
  logic [3:0]  req_op = 4'd0;
  logic [63:0] req_a = 64'd0;
  logic [63:0] req_b = 64'd0;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_data;
  logic        alu_ce;
  logic [15:0] alu_i1, alu_i2, alu_sum, alu_sub;

  int n_tests = 0;
  int n_fail  = 0;
  int cycle   = 0;
  int model_ptr = 0;
  int          exp_id_q[$];
  logic [15:0] exp_data_q[$];
  int          grant_log[$];
  int          grant_cyc[$];

  math_pipelined_arbiter #(.WIDTH(WIDTH), .ALU_LATENCY(ALU_LATENCY), .N_REQ(N_REQ)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .alu_ce(alu_ce), .alu_i1(alu_i1), .alu_i2(alu_i2), .alu_sum(alu_sum), .alu_sub(alu_sub)
  );

  always #5 clk = ~clk;

  // Shared unit model: result is wrong until ALU_LATENCY cycles after the ce cycle.
  int alu_cnt = 0;
  always @(posedge clk) begin
    if (alu_ce) alu_cnt <= ALU_LATENCY - 1;
    else if (alu_cnt > 0) alu_cnt <= alu_cnt - 1;
  end
  assign alu_sum = (alu_cnt == 0) ? 16'(alu_i1 + alu_i2) : ~16'(alu_i1 + alu_i2);
  assign alu_sub = (alu_cnt == 0) ? 16'(alu_i1 - alu_i2) : ~16'(alu_i1 - alu_i2);

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  function automatic int rr_pick(input logic [3:0] v, input int p);
    for (int k = 0; k < N_REQ; k++) begin
      if (v[(p + k) % N_REQ]) return (p + k) % N_REQ;
    end
    return -1;
  endfunction

  function automatic logic [15:0] ref_result(input logic op, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    r = op ? (a - b) : (a + b);
    return r;
  endfunction

  task automatic set_req(input int i, input logic op, input logic [15:0] a, input logic [15:0] b);
    req_op[i] = op;
    req_a[i*16 +: 16] = a;
    req_b[i*16 +: 16] = b;
  endtask

  task automatic rand_req(input int i);
    set_req(i, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = 4'd0;
    tick();
    tick();
    rst_n = 1'b1;
    model_ptr = 0;
    exp_id_q.delete();
    exp_data_q.delete();
    grant_log.delete();
    grant_cyc.delete();
  endtask

  task automatic check_zero_outputs(input string pfx);
    check({pfx, "_req_ready"}, 32'(req_ready), 32'd0);
    check({pfx, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({pfx, "_rsp_id"},    32'(rsp_id),    32'd0);
    check({pfx, "_rsp_data"},  32'(rsp_data),  32'd0);
    check({pfx, "_alu_ce"},    32'(alu_ce),    32'd0);
    check({pfx, "_alu_i1"},    32'(alu_i1),    32'd0);
    check({pfx, "_alu_i2"},    32'(alu_i2),    32'd0);
  endtask

  // Drive/observe until n_ops responses are consumed, predicting grants and results.
  task automatic service(input int n_ops, input bit keep, input bit rnd);
    int done = 0;
    int cyc  = 0;
    int g;
    while (done < n_ops && cyc < 600) begin
      if (rnd) begin
        req_valid = 4'($urandom_range(0, 15));
        for (int i = 0; i < N_REQ; i++) rand_req(i);
        rsp_ready = 1'($urandom_range(0, 1));
      end
      #1;
      g = -1;
      if (rsp_valid) check("busy_ready", 32'(req_ready), 32'd0);
      if (req_ready != 4'd0) begin
        g = rr_pick(req_valid, model_ptr);
        check("grant", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
        if (g >= 0) begin
          exp_id_q.push_back(g);
          exp_data_q.push_back(ref_result(req_op[g], req_a[g*16 +: 16], req_b[g*16 +: 16]));
          model_ptr = (g + 1) % N_REQ;
          grant_log.push_back(g);
          grant_cyc.push_back(cycle);
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_id_q.size() == 0) begin
          check("spurious_rsp", 32'(rsp_valid), 32'd0);
        end else begin
          check("rsp_id", 32'(rsp_id), 32'(exp_id_q.pop_front()));
          check("rsp_data", 32'(rsp_data), 32'(exp_data_q.pop_front()));
        end
        done++;
      end
      tick();
      cyc++;
      if (g >= 0 && !rnd) begin
        if (!keep) req_valid[g] = 1'b0;
        rand_req(g);
      end
    end
    check("ops_completed", 32'(done), 32'(n_ops));
  endtask

  initial begin
    int lat;
    int seen;
    logic [15:0] exp_d;

    // Reset hold, release with no requests.
    do_reset();
    tick();
    check_zero_outputs("reset");

    // Requester 2 add 0x1234+0x0FCD, with latency measurement.
    set_req(2, 1'b0, 16'h1234, 16'h0FCD);
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    #1;
    check("grant_r2", 32'(req_ready), 32'h4);
    tick();
    req_valid = 4'd0;
    rand_req(2);
    model_ptr = 3;
    lat = 1;
    check("load_alu_ce", 32'(alu_ce), 32'd1);
    check("load_alu_i1", 32'(alu_i1), 32'h1234);
    check("load_alu_i2", 32'(alu_i2), 32'h0FCD);
    check("load_req_ready", 32'(req_ready), 32'd0);
    tick();
    lat = 2;
    check("run_alu_ce", 32'(alu_ce), 32'd0);
    while (!rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("latency", 32'(lat), 32'd6);
    check("r2_data", 32'(rsp_data), 32'h2201);
    check("r2_id", 32'(rsp_id), 32'd2);
    tick();
    check("r2_valid_drop", 32'(rsp_valid), 32'd0);

    // Wrap cases: 0x0000-0x0001 from requester 0, 0xFFFF+0x0001 from requester 1.
    set_req(0, 1'b1, 16'h0000, 16'h0001);
    set_req(1, 1'b0, 16'hFFFF, 16'h0001);
    req_valid = 4'b0011;
    service(2, 1'b0, 1'b0);
    check("wrap_order_len", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() == 2) begin
      check("wrap_first", 32'(grant_log[0]), 32'd0);
      check("wrap_second", 32'(grant_log[1]), 32'd1);
    end
    req_valid = 4'd0;

    // All four requesting continuously: strict rotation at full throughput.
    do_reset();
    for (int i = 0; i < N_REQ; i++) rand_req(i);
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    service(8, 1'b1, 1'b0);
    req_valid = 4'd0;
    check("rot_len", 32'(grant_log.size()), 32'd8);
    for (int i = 0; i < 8 && i < grant_log.size(); i++)
      check("rot_order", 32'(grant_log[i]), 32'(i % N_REQ));
    for (int i = 1; i < grant_cyc.size(); i++)
      check("throughput", 32'(grant_cyc[i] - grant_cyc[i-1]), 32'(ALU_LATENCY + 3));

    // Back-pressure: response held for 10 cycles while another requester waits.
    rand_req(3);
    req_valid = 4'b1000;
    #1;
    check("bp_grant", 32'(req_ready), 32'(1 << rr_pick(req_valid, model_ptr)));
    exp_d = ref_result(req_op[3], req_a[48 +: 16], req_b[48 +: 16]);
    model_ptr = 0;
    tick();
    req_valid = 4'd0;
    rand_req(3);
    rsp_ready = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("bp_rsp_seen", 32'(rsp_valid), 32'd1);
    req_valid = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_data", 32'(rsp_data), 32'(exp_d));
      check("bp_id", 32'(rsp_id), 32'd3);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    check("bp_valid_drop", 32'(rsp_valid), 32'd0);
    #1;
    check("bp_idle_grant", 32'(req_ready), 32'(1 << rr_pick(req_valid, model_ptr)));
    service(1, 1'b0, 1'b0);
    req_valid = 4'd0;

    // Reset during RUN abandons the operation.
    rand_req(1);
    req_valid = 4'b0010;
    #1;
    check("abort_grant", 32'(req_ready), 32'(1 << rr_pick(req_valid, model_ptr)));
    tick();
    req_valid = 4'd0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check_zero_outputs("abort");
    rst_n = 1'b1;
    model_ptr = 0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rsp_valid) seen++;
    end
    check("abort_no_rsp", 32'(seen), 32'd0);
    rand_req(1);
    req_valid = 4'b0010;
    service(1, 1'b0, 1'b0);
    req_valid = 4'd0;

    // Randomized traffic and back-pressure against the reference model.
    service(40, 1'b0, 1'b1);
    req_valid = 4'd0;
    rsp_ready = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/math_pipelined_arbiter.md
Name: math_pipelined_arbiter

Overview:
- Round-robin controller that shares one chunked pipelined add/sub unit (math_pipelined) between N_REQ requesters.
- Accepts one operation per grant, sequences the unit's ce/operand protocol, and waits out the carry-ripple latency.
- Returns the selected result (sum or sub), tagged with the requester index, over a valid/ready response port.
- Sits between client blocks (counters, accumulators) and the shared unit; exactly one operation is in flight at any time.

Parameters:
- WIDTH, 16, operand/result width; must match the attached unit.
- ALU_LATENCY, 4, cycles from the alu_ce pulse to a stable result; must match the unit's LATENCY; >=1.
- N_REQ, 4, number of requesters; >=2.
- ID_W, $clog2(N_REQ), localparam, width of rsp_id.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  N_REQ  per-requester operation request.
- req_op  in  N_REQ  per-requester op select: 0=add, 1=sub.
- req_a  in  N_REQ*WIDTH  flattened operand A; slice i*WIDTH+:WIDTH belongs to requester i.
- req_b  in  N_REQ*WIDTH  flattened operand B, same packing as req_a.
- req_ready  out  N_REQ  one-hot accept; a transfer occurs when req_valid[i]&req_ready[i].
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_id  out  ID_W  index of the requester that owns the result.
- rsp_data  out  WIDTH  result, modulo 2^WIDTH.
- alu_ce  out  1  unit clock-enable/load strobe.
- alu_i1  out  WIDTH  unit operand I1 (A).
- alu_i2  out  WIDTH  unit operand I2 (B).
- alu_sum  in  WIDTH  unit sum output.
- alu_sub  in  WIDTH  unit difference output.

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE, rr_ptr=0.
  - req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0.
  - alu_ce=0, alu_i1=0, alu_i2=0.
  - Reset mid-operation abandons the operation; no response is emitted for it.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - req_ready is combinational: one-hot on the first asserted req_valid at or after rr_ptr, searching upward with wrap; all zero if no request.
  - On grant i: latch A, B and op into alu_i1, alu_i2 and op_r; set id_r=i; go to LOAD.
  - rr_ptr <= (i+1) mod N_REQ.
- LOAD:
  - alu_ce=1 for exactly this cycle.
  - Load cnt=ALU_LATENCY-1; go to RUN.
- RUN:
  - alu_ce=0; alu_i1/alu_i2 held stable.
  - cnt decrements each cycle. When cnt==0, register rsp_data = op_r ? alu_sub : alu_sum and rsp_id=id_r; go to DONE.
  - The result is therefore sampled exactly ALU_LATENCY cycles after the alu_ce cycle.
- DONE:
  - rsp_valid=1; rsp_data and rsp_id held stable while rsp_valid&!rsp_ready.
  - On rsp_ready: rsp_valid deasserts next cycle and state returns to IDLE.
  - The next grant is possible in the cycle after the handshake; no bypass.
- req_ready is 0 in every state except IDLE. Requester inputs are sampled only at the grant edge; later changes have no effect.
- Throughput: at most one operation per ALU_LATENCY+3 cycles when rsp_ready is held high.
- Fairness:
  - A requester holding req_valid continuously is granted within N_REQ grants.
  - Simultaneous requests are resolved purely by rr_ptr.
- Arithmetic:
  - No carry/borrow out is reported.
  - add wraps (0xFFFF+1 = 0x0000 at WIDTH=16).
  - sub wraps (0x0000-1 = 0xFFFF).

Decomposition:
- Shared package holds:
  - op encodings OP_ADD=1'b0, OP_SUB=1'b1;
  - FSM state encoding (2 bits);
  - a clog2 helper function.
- The natural sub-module is rr_arbiter (N_REQ parameter): combinational one-hot grant from req_valid and rr_ptr, plus pointer-advance logic.
- The FSM and operand registers stay in the top module.
- The verification bench instantiates math_pipelined with WIDTH/LATENCY tied to this block's parameters.

Test Plan (all scenarios use defaults WIDTH=16, ALU_LATENCY=4, N_REQ=4):
- Reset hold, then release with no requests -> all outputs 0, state IDLE, req_ready=0.
- Requester 2 add 0x1234+0x0FCD, rsp_ready=1 -> rsp_valid rises 6 cycles after the grant edge with rsp_data=0x2201, rsp_id=2.
- Requester 0 sub 0x0000-0x0001, then requester 1 add 0xFFFF+0x0001 -> responses 0xFFFF id 0, then 0x0000 id 1.
- All four req_valid held high for 8 operations -> grant order 0,1,2,3,0,1,2,3; no requester is granted twice before the others.
- rsp_ready held low for 10 cycles in DONE -> rsp_valid, rsp_data and rsp_id stable; req_ready=0 throughout; IDLE one cycle after rsp_ready.
- rst_n asserted during RUN -> next cycle IDLE and all outputs 0; no rsp_valid for the aborted operation; a new request completes correctly.
